sweep_sequencer: RTL and testbench

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

---
 rtl/params.sv | 19 +
 rtl/sweep_addr_counter.sv | 50 +++++
 rtl/sweep_sequencer.sv | 128 ++++++++++++
 tb/tb_sweep_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params.sv
// Shared constants and state encoding for the sweep sequencer.
// Address widths are sized for the default grid; smaller grids reuse them.
package params;

    localparam int GRID_W_DEF = 160;
    localparam int GRID_H_DEF = 120;
    localparam int X_bits     = $clog2(GRID_W_DEF);
    localparam int Y_bits     = $clog2(GRID_H_DEF);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_WRITE   = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4,
        ST_PAUSED  = 3'd5
    } sweep_state_t;

endpackage

// File: rtl/sweep_addr_counter.sv
// Column/row address registers for the sweep, with lane masking and
// detection of the final beat of the grid.
module sweep_addr_counter
    import params::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int LANES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [X_bits-1:0] x,
    output logic [Y_bits-1:0] y,
    output logic [LANES-1:0]  lane_valid,
    output logic              last_beat
);

    localparam logic [X_bits:0]   LANES_X  = (X_bits + 1)'(LANES);
    localparam logic [X_bits:0]   GRID_W_X = (X_bits + 1)'(GRID_W);
    localparam logic [Y_bits-1:0] LAST_Y   = Y_bits'(GRID_H - 1);

    // One extra bit so base + LANES cannot overflow before the wrap test.
    logic [X_bits:0] x_sum;
    logic            row_end;

    assign x_sum     = {1'b0, x} + LANES_X;
    assign row_end   = (x_sum >= GRID_W_X);
    assign last_beat = (y == LAST_Y) && row_end;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (row_end) begin
                x <= '0;
                y <= y + Y_bits'(1);
            end else begin
                x <= x_sum[X_bits-1:0];
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_valid[i] = (({1'b0, x} + (X_bits + 1)'(i)) < GRID_W_X);
    end

endmodule

// File: rtl/sweep_sequencer.sv
// Walks the grid one beat at a time, holding each address for a settle
// period before raising a write request to the environment.
module sweep_sequencer
    import params::*;
#(
    parameter int GRID_W     = GRID_W_DEF,
    parameter int GRID_H     = GRID_H_DEF,
    parameter int LANES      = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic              newLocClock,
    input  logic              RESET_SIM,
    input  logic              RUN,
    input  logic              tick,
    input  logic              PAUSE,
    input  logic              step,
    input  logic              env_ready,
    output logic [X_bits-1:0] writeLoc_x,
    output logic [Y_bits-1:0] writeLoc_y,
    output logic [LANES-1:0]  lane_valid,
    output logic              write_flag,
    output logic              hold_locs,
    output logic              sweep_done,
    output logic [15:0]       generation,
    output logic [7:0]        missed_ticks,
    output logic [2:0]        sim_state
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_SETTLE  = ST_SETTLE;
    localparam logic [2:0] S_WRITE   = ST_WRITE;
    localparam logic [2:0] S_ADVANCE = ST_ADVANCE;
    localparam logic [2:0] S_DONE    = ST_DONE;
    localparam logic [2:0] S_PAUSED  = ST_PAUSED;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] settle_cnt;
    logic       by_step;
    logic       start_req;
    logic       transfer;
    logic       last_beat;
    logic       addr_clear;
    logic       addr_advance;

    // Handshake: write_flag is a registered request that stays high with a
    // stable address until the cycle env_ready is also high; that cycle is
    // the transfer, and write_flag drops on the following edge.
    assign start_req = RUN && ((tick && !PAUSE) || step);
    assign transfer  = write_flag && env_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_req) state_nxt = S_SETTLE;
            S_SETTLE:  if (settle_cnt <= 4'd1) state_nxt = S_WRITE;
            S_WRITE:   if (transfer) state_nxt = last_beat ? S_DONE : S_ADVANCE;
            S_ADVANCE: state_nxt = (PAUSE && !by_step) ? S_PAUSED : S_SETTLE;
            S_PAUSED:  if (!PAUSE || step) state_nxt = S_SETTLE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (!RUN) state_nxt = S_IDLE;
    end

    always_ff @(posedge newLocClock) begin
        if (RESET_SIM) begin
            state        <= S_IDLE;
            settle_cnt   <= 4'd0;
            by_step      <= 1'b0;
            write_flag   <= 1'b0;
            sweep_done   <= 1'b0;
            generation   <= 16'd0;
            missed_ticks <= 8'd0;
        end else begin
            state      <= state_nxt;
            write_flag <= (state_nxt == S_WRITE);
            sweep_done <= (state_nxt == S_DONE);

            // Reload on every entry to SETTLE; staying there implies count > 1.
            if (state_nxt == S_SETTLE) begin
                settle_cnt <= (state != S_SETTLE) ? SETTLE_LOAD : settle_cnt - 4'd1;
            end else begin
                settle_cnt <= 4'd0;
            end

            if (state == S_IDLE && state_nxt == S_SETTLE) begin
                by_step <= step;
            end else if (state == S_PAUSED && step && RUN) begin
                by_step <= 1'b1;
            end else if (state_nxt == S_IDLE) begin
                by_step <= 1'b0;
            end

            if (state_nxt == S_DONE && state != S_DONE) begin
                generation <= generation + 16'd1;
            end

            if (state != S_IDLE && (tick || step) && missed_ticks != 8'hFF) begin
                missed_ticks <= missed_ticks + 8'd1;
            end
        end
    end

    assign addr_clear   = (state_nxt == S_IDLE);
    assign addr_advance = (state == S_ADVANCE);

    sweep_addr_counter #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .LANES  (LANES)
    ) u_addr (
        .clk        (newLocClock),
        .rst        (RESET_SIM),
        .clear      (addr_clear),
        .advance    (addr_advance),
        .x          (writeLoc_x),
        .y          (writeLoc_y),
        .lane_valid (lane_valid),
        .last_beat  (last_beat)
    );

    assign hold_locs = (state != S_ADVANCE);
    assign sim_state = state;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer on a 5x3 grid with two lanes.
// Expected beats come from a plain row/column walk of the grid.
module tb_sweep_sequencer;
    import params::*;

    localparam int GW = 5;
    localparam int GH = 3;
    localparam int LN = 2;
    localparam int SC = 2;
    localparam int BW = Y_bits + X_bits + LN;

    logic              clk = 1'b0;
    logic              RESET_SIM, RUN, tick, PAUSE, step, env_ready;
    logic [X_bits-1:0] writeLoc_x;
    logic [Y_bits-1:0] writeLoc_y;
    logic [LN-1:0]     lane_valid;
    logic              write_flag, hold_locs, sweep_done;
    logic [15:0]       generation;
    logic [7:0]        missed_ticks;
    logic [2:0]        sim_state;

    sweep_sequencer #(
        .GRID_W (GW), .GRID_H (GH), .LANES (LN), .SETTLE_CYC (SC)
    ) dut (
        .newLocClock  (clk),
        .RESET_SIM    (RESET_SIM),
        .RUN          (RUN),
        .tick         (tick),
        .PAUSE        (PAUSE),
        .step         (step),
        .env_ready    (env_ready),
        .writeLoc_x   (writeLoc_x),
        .writeLoc_y   (writeLoc_y),
        .lane_valid   (lane_valid),
        .write_flag   (write_flag),
        .hold_locs    (hold_locs),
        .sweep_done   (sweep_done),
        .generation   (generation),
        .missed_ticks (missed_ticks),
        .sim_state    (sim_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [BW-1:0] exp_q[$];
    logic [15:0]   done_q[$];
    logic [15:0]   exp_gen = 16'd0;
    int            exp_missed = 0;
    int            checks = 0;
    int            errors = 0;
    bit            rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Model of one sweep: every row, columns stepping by LN, lanes masked at the grid edge.
    task automatic push_sweep();
        logic [LN-1:0] lv;
        for (int yy = 0; yy < GH; yy++) begin
            for (int xx = 0; xx < GW; xx += LN) begin
                for (int i = 0; i < LN; i++) lv[i] = (xx + i < GW);
                exp_q.push_back({Y_bits'(yy), X_bits'(xx), lv});
            end
        end
        exp_gen = exp_gen + 16'd1;
        done_q.push_back(exp_gen);
    endtask

    task automatic drop_sweep();
        exp_q.delete();
        done_q.delete();
    endtask

    // ---------------- monitor ----------------
    logic              prev_stall = 1'b0;
    logic [X_bits-1:0] px;
    logic [Y_bits-1:0] py;
    logic [BW-1:0]     e_beat;
    logic [15:0]       e_gen;

    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_flag", 32'(write_flag), 32'd1);
            check("stall_addr", 32'({writeLoc_y, writeLoc_x}), 32'({py, px}));
        end
        if (write_flag && env_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("xfer_unexpected");
            end else begin
                e_beat = exp_q.pop_front();
                check("xfer_beat", 32'({writeLoc_y, writeLoc_x, lane_valid}), 32'(e_beat));
            end
        end
        if (sweep_done) begin
            if (done_q.size() == 0) begin
                fail_now("done_unexpected");
            end else begin
                e_gen = done_q.pop_front();
                check("done_generation", 32'(generation), 32'(e_gen));
            end
        end
        prev_stall = write_flag && !env_ready && RUN && !RESET_SIM;
        px = writeLoc_x;
        py = writeLoc_y;
    end

    // Random env_ready, applied after any directed drive of the same cycle.
    always @(posedge clk) begin
        #2;
        if (rand_ready) env_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_sweep(input bit t, input bit s);
        push_sweep();
        tick = t;
        step = s;
        cyc(1);
        tick = 1'b0;
        step = 1'b0;
    endtask

    task automatic pulse_ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
        exp_missed = (exp_missed + n > 255) ? 255 : exp_missed + n;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_q.size() != 0 && n < 3000) begin
            cyc(1);
            n++;
        end
        if (done_q.size() != 0) begin
            fail_now({name, "_timeout"});
            drop_sweep();
        end
        cyc(2);
    endtask

    task automatic wait_beat(input int bx, input int by);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 500) begin
            @(negedge clk);
            if (write_flag && writeLoc_x == X_bits'(bx) && writeLoc_y == Y_bits'(by)) seen = 1'b1;
            n++;
        end
        if (!seen) fail_now("wait_beat_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_state"}, 32'(sim_state), 32'd0);
        check({name, "_x"}, 32'(writeLoc_x), 32'd0);
        check({name, "_y"}, 32'(writeLoc_y), 32'd0);
        check({name, "_wflag"}, 32'(write_flag), 32'd0);
        check({name, "_done"}, 32'(sweep_done), 32'd0);
        check({name, "_hold"}, 32'(hold_locs), 32'd1);
        check({name, "_gen"}, 32'(generation), 32'(exp_gen));
        check({name, "_missed"}, 32'(missed_ticks), 32'(exp_missed));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RESET_SIM = 1'b1; RUN = 1'b0; tick = 1'b0; PAUSE = 1'b0; step = 1'b0; env_ready = 1'b0;
        cyc(3);
        RESET_SIM = 1'b0;
        cyc(1);
        check_idle("reset");
        check("reset_lanes", 32'(lane_valid), 32'b11);

        RUN = 1'b1;
        env_ready = 1'b1;
        cyc(1);

        // Plain sweep from a tick.
        start_sweep(1'b1, 1'b0);
        wait_done("sweep1");
        check_idle("after_sweep1");

        // Three ticks while busy are counted, not queued.
        start_sweep(1'b1, 1'b0);
        cyc(3);
        pulse_ticks(3);
        wait_done("sweep_missed");
        check("missed_three", 32'(missed_ticks), 32'd3);

        // A tick under PAUSE in IDLE starts nothing.
        PAUSE = 1'b1;
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(6);
        check_idle("paused_tick");

        // A step runs one full sweep straight through PAUSE.
        start_sweep(1'b0, 1'b1);
        wait_done("step_sweep");
        check_idle("after_step");
        PAUSE = 1'b0;
        cyc(1);

        // PAUSE raised during beat (2,0) parks at the next beat address.
        start_sweep(1'b1, 1'b0);
        wait_beat(2, 0);
        PAUSE = 1'b1;
        cyc(2);
        check("pause_state", 32'(sim_state), 32'd5);
        check("pause_x", 32'(writeLoc_x), 32'd4);
        check("pause_y", 32'(writeLoc_y), 32'd0);
        check("pause_wflag", 32'(write_flag), 32'd0);
        cyc(5);
        check("pause_still", 32'(sim_state), 32'd5);
        check("pause_still_x", 32'(writeLoc_x), 32'd4);
        PAUSE = 1'b0;
        wait_done("pause_resume");

        // Tick and step together start exactly one sweep.
        start_sweep(1'b1, 1'b1);
        wait_done("tick_step");
        check("tick_step_missed", 32'(missed_ticks), 32'(exp_missed));

        // RUN dropped just after beat (2,1) aborts the sweep.
        start_sweep(1'b1, 1'b0);
        wait_beat(2, 1);
        RUN = 1'b0;
        drop_sweep();
        exp_gen = exp_gen - 16'd1;
        cyc(1);
        check_idle("abort");
        cyc(4);
        check_idle("abort_hold");
        RUN = 1'b1;
        cyc(1);

        // Randomized sweeps with random back-pressure and stray ticks.
        rand_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            int kind = $urandom_range(0, 2);
            int k    = $urandom_range(0, 3);
            start_sweep(kind != 1, kind != 0);
            cyc(2);
            pulse_ticks(k);
            wait_done("rand_sweep");
            check("rand_missed", 32'(missed_ticks), 32'(exp_missed));
            cyc($urandom_range(0, 4));
        end
        rand_ready = 1'b0;
        env_ready = 1'b1;
        cyc(1);

        // Long stall in WRITE while 300 ticks arrive saturates the counter.
        start_sweep(1'b1, 1'b0);
        cyc(1);
        env_ready = 1'b0;
        pulse_ticks(300);
        check("missed_saturate", 32'(missed_ticks), 32'd255);
        check("stall_state", 32'(sim_state), 32'd2);
        env_ready = 1'b1;
        wait_done("saturate_sweep");

        // Reset mid-sweep clears everything.
        start_sweep(1'b1, 1'b0);
        cyc(7);
        env_ready = 1'b0;
        RESET_SIM = 1'b1;
        drop_sweep();
        exp_gen = 16'd0;
        exp_missed = 0;
        cyc(1);
        RESET_SIM = 1'b0;
        check_idle("mid_reset");
        env_ready = 1'b1;
        start_sweep(1'b1, 1'b0);
        wait_done("post_reset");
        check("post_reset_gen", 32'(generation), 32'd1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
